// File: rtl/demux_pkg.sv
// Shared definitions for the demux_dispatch block.
package demux_pkg;

    localparam int unsigned NUM_CH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic MODE_ADDR = 1'b0;
    localparam logic MODE_RR   = 1'b1;

endpackage

// File: rtl/demux_dispatch_rr_pick.sv
// Rotating-priority picker: first set bit of mask, scanning cyclically from ptr.
module rr_pick
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [1:0]        ptr,
    output logic [1:0]        idx,
    output logic              found
);

    // Scan ptr, ptr+1, ... with 2-bit wraparound; keep the first hit.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!found && mask[ptr + 2'(i)]) begin
                idx   = ptr + 2'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_dispatch.sv
// One-word holding buffer that routes each word to one of four channels,
// either by explicit destination or round-robin over the enabled channels.
module demux_dispatch #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUM_CH = demux_pkg::NUM_CH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode,
    input  logic [NUM_CH-1:0] chan_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [1:0]        in_dest,
    output logic [NUM_CH-1:0] out_valid,
    input  logic [NUM_CH-1:0] out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [7:0]        drop_cnt,
    output logic              busy
);
    import demux_pkg::*;

    state_e           state_q, state_d;
    logic [1:0]       tgt_q, tgt_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;

    logic       fire, accept, take, drop, any_en;
    logic [1:0] scan_ptr, rr_idx, pick;
    logic       rr_found;

    // Round-robin scan starts past a target that fires this cycle, so a
    // back-to-back refill never re-picks the channel just served.
    rr_pick u_rr_pick (
        .mask  (chan_en),
        .ptr   (scan_ptr),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // Handshake decode and next-state computation.
    always_comb begin
        any_en   = |chan_en;
        fire     = (state_q == SEND) && out_ready[tgt_q];
        // rst_n gating keeps in_ready low for the whole reset window.
        in_ready = rst_n && any_en && ((state_q == IDLE) || fire);
        accept   = in_valid && in_ready;
        scan_ptr = fire ? tgt_q + 2'd1 : rr_ptr_q;
        pick     = (mode == MODE_RR) ? rr_idx : in_dest;
        take     = accept && ((mode == MODE_RR) ? rr_found : chan_en[in_dest]);
        drop     = accept && (mode == MODE_ADDR) && !chan_en[in_dest];

        state_d    = state_q;
        tgt_d      = tgt_q;
        hold_d     = hold_q;
        rr_ptr_d   = rr_ptr_q;
        drop_cnt_d = drop_cnt_q;

        if (fire) begin
            rr_ptr_d = tgt_q + 2'd1;
            state_d  = IDLE;
        end
        if (take) begin
            state_d = SEND;
            tgt_d   = pick;
            hold_d  = in_data;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tgt_q      <= '0;
            rr_ptr_q   <= '0;
            hold_q     <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tgt_q      <= tgt_d;
            rr_ptr_q   <= rr_ptr_d;
            hold_q     <= hold_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Outputs decode straight from registers.
    always_comb begin
        busy      = (state_q == SEND);
        out_valid = busy ? (NUM_CH'(1) << tgt_q) : '0;
        out_data  = hold_q;
        drop_cnt  = drop_cnt_q;
    end

endmodule

// File: tb/tb_demux_dispatch.sv
// Directed self-checking bench for demux_dispatch.
module tb_demux_dispatch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mode;
    logic [3:0] chan_en;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic [1:0] in_dest;
    logic [3:0] out_valid;
    logic [3:0] out_ready;
    logic [7:0] out_data;
    logic [7:0] drop_cnt;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    demux_dispatch #(
        .WIDTH  (8),
        .NUM_CH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .chan_en   (chan_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] rr_exp [4];
        logic [3:0] seen_ov;
        logic       bad;
        rr_exp = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};

        // Reset state, with inputs that would otherwise be accepted.
        rst_n = 1'b0; mode = 1'b0; chan_en = 4'hF; in_valid = 1'b1;
        in_data = 8'hEE; in_dest = 2'd0; out_ready = 4'hF;
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk); rst_n = 1'b1; in_valid = 1'b0;

        // Addressed routing, back-to-back to dest 2, 0, 3.
        @(negedge clk); in_valid = 1'b1; in_data = 8'h11; in_dest = 2'd2;
        #1 check("addr_rdy_idle", in_ready, 1);
        @(negedge clk); in_data = 8'h22; in_dest = 2'd0;
        #1 check("addr_ov0", out_valid, 4'b0100); check("addr_od0", out_data, 8'h11);
        @(negedge clk); in_data = 8'h33; in_dest = 2'd3;
        #1 check("addr_ov1", out_valid, 4'b0001); check("addr_od1", out_data, 8'h22);
        @(negedge clk); in_valid = 1'b0;
        #1 check("addr_ov2", out_valid, 4'b1000); check("addr_od2", out_data, 8'h33);
        check("addr_rdy_fire", in_ready, 1);
        @(negedge clk);
        #1 check("addr_idle_ov", out_valid, 0); check("addr_idle_od", out_data, 8'h33);
        check("addr_idle_busy", busy, 0);

        // Round-robin over mask 1010, four back-to-back words.
        @(negedge clk); mode = 1'b1; chan_en = 4'b1010; in_valid = 1'b1; in_data = 8'hA0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 3) in_data = 8'hA1 + 8'(k);
            else in_valid = 1'b0;
            #1 check($sformatf("rr_ov%0d", k), out_valid, rr_exp[k]);
            check($sformatf("rr_od%0d", k), out_data, 8'hA0 + 8'(k));
        end
        @(negedge clk);
        #1 check("rr_idle_ov", out_valid, 0);

        // Backpressure on channel 2; mode/mask changes must not disturb the held word.
        @(negedge clk); mode = 1'b0; chan_en = 4'hF; in_valid = 1'b1;
        in_data = 8'h5A; in_dest = 2'd2; out_ready = 4'b1011;
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); mode = 1'b1; chan_en = 4'b0001; in_data = 8'h66;
            #1;
            if (out_valid !== 4'b0100 || out_data !== 8'h5A || in_ready !== 1'b0
                || busy !== 1'b1) bad = 1'b1;
        end
        check("bp_stall_stable", bad, 0);
        check("bp_stall_ov", out_valid, 4'b0100);
        @(negedge clk); in_valid = 1'b0; out_ready = 4'hF;
        #1 check("bp_fire_ov", out_valid, 4'b0100); check("bp_fire_rdy", in_ready, 1);
        @(negedge clk);
        #1 check("bp_done_busy", busy, 0); check("bp_rr_ptr", dut.rr_ptr_q, 3);

        // Drop path: 300 words to a disabled destination.
        @(negedge clk); mode = 1'b0; chan_en = 4'b0111; in_dest = 2'd3;
        in_data = 8'hC3; in_valid = 1'b1;
        seen_ov = 4'b0000;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1 seen_ov = seen_ov | out_valid;
            if (i == 9) check("drop_cnt10", drop_cnt, 10);
        end
        in_valid = 1'b0;
        check("drop_no_ov", seen_ov, 0);
        check("drop_sat", drop_cnt, 255);

        // All channels disabled: nothing accepted for 10 cycles.
        @(negedge clk); chan_en = 4'b0000; in_valid = 1'b1; in_dest = 2'd0;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1 if (in_ready !== 1'b0 || busy !== 1'b0 || out_valid !== 4'b0000) bad = 1'b1;
        end
        check("dis_idle", bad, 0);
        check("dis_drop_hold", drop_cnt, 255);

        // Reset pulse in SEND, then round-robin restarts at channel 0.
        @(negedge clk); chan_en = 4'hF; in_dest = 2'd1; in_data = 8'h99; out_ready = 4'h0;
        @(negedge clk); in_valid = 1'b0;
        #1 check("rst_mid_ov_pre", out_valid, 4'b0010);
        rst_n = 1'b0;
        #1 check("rst_mid_ov", out_valid, 0); check("rst_mid_busy", busy, 0);
        check("rst_mid_od", out_data, 0); check("rst_mid_drop", drop_cnt, 0);
        @(negedge clk); rst_n = 1'b1;
        #1 check("rst_rel_ptr", dut.rr_ptr_q, 0); check("rst_rel_busy", busy, 0);
        mode = 1'b1; in_valid = 1'b1; in_data = 8'h77; out_ready = 4'hF;
        // While word 0x77 fires, offer a word to a disabled destination.
        @(negedge clk); mode = 1'b0; chan_en = 4'b0111; in_dest = 2'd3; in_data = 8'h88;
        #1 check("rst_rr_ov", out_valid, 4'b0001); check("rst_rr_od", out_data, 8'h77);
        check("send_drop_rdy", in_ready, 1);
        @(negedge clk); in_valid = 1'b0;
        #1 check("send_drop_busy", busy, 0); check("send_drop_cnt", drop_cnt, 1);
        check("send_drop_od", out_data, 8'h77); check("send_drop_ptr", dut.rr_ptr_q, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
